// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Drives PC and pipe-register enables and flushes, a stall status code, a
// sticky halt flag, and saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_dataread,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_br_taken,
  input  logic             id_jump,
  input  logic             ex_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [2:0]       stall,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // IDEX_STALL and EXMEM_STALL are part of the shared encoding but unused here.
  typedef enum logic [2:0] {
    NO_STALL    = 3'd0,
    IFID_STALL  = 3'd1,
    IDEX_STALL  = 3'd2,
    EXMEM_STALL = 3'd3,
    FULL_STALL  = 3'd4
  } pipe_stall_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic             halt_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  pipe_stall_t      stall_e;
  logic             flush_ev;
  logic             dwait, load_use;

  assign dwait    = mem_req & ~dhit;
  assign load_use = ex_dataread & (ex_wsel != 5'd0) &
                    ((ex_wsel == id_rs) | (ex_wsel == id_rt));

  // Next state, enables, flushes and stall code by priority within each state
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_e    = FULL_STALL;
    flush_ev   = 1'b0;
    if (RST) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (dwait) begin
            stall_e = FULL_STALL;
          end else if (ex_halt) begin
            // Halt in EX: stop fetching and bubble younger stages immediately.
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            stall_e    = IFID_STALL;
          end else if (ex_br_taken) begin
            // Taken branch beats an imem miss: the wrong-path fetch is discarded.
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            stall_e    = NO_STALL;
            flush_ev   = 1'b1;
          end else if (!ihit) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            ifid_flush = 1'b1;
            stall_e    = IFID_STALL;
          end else if (load_use) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_flush = 1'b1;
            stall_e    = IFID_STALL;
          end else if (id_jump) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush = 1'b1;
            stall_e    = NO_STALL;
            flush_ev   = 1'b1;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            stall_e = NO_STALL;
          end
          if (wb_halt)                 state_d = HALTED;
          else if (ex_halt && !dwait)  state_d = DRAIN;
        end
        DRAIN: begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = ~dwait;
          memwb_en   = ~dwait;
          stall_e    = dwait ? FULL_STALL : IFID_STALL;
          if (wb_halt) state_d = HALTED;
        end
        HALTED: state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  assign stall        = stall_e;
  assign halt         = halt_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

  // State, sticky halt and saturating counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d == HALTED);
      if (state_q != HALTED && stall_e != NO_STALL && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush_ev && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed test-plan sequences plus randomized traffic,
// checked by a scoreboard queue against a behavioural model.
module tb_pipeline_ctrl;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [2:0] NO = 3'd0, IFID = 3'd1, FULL = 3'd4;

  logic CLK = 1'b0, RST = 1'b1;
  logic ihit, dhit, mem_req, ex_dataread, ex_br_taken, id_jump, ex_halt, wb_halt;
  logic [4:0] id_rs, id_rt, ex_wsel;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
  logic [2:0] stall;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .id_rs(id_rs), .id_rt(id_rt), .ex_dataread(ex_dataread), .ex_wsel(ex_wsel),
    .ex_br_taken(ex_br_taken), .id_jump(id_jump), .ex_halt(ex_halt), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall(stall), .halt(halt), .stall_cycles(stall_cycles), .flush_count(flush_count));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] en;   // pc, ifid, idex, exmem, memwb
    logic [1:0] fl;   // ifid, idex
    logic [2:0] st;
    logic       h;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;

  // Model state: 0 = running, 1 = draining, 2 = halted
  int  m_mode = 0;
  bit  m_halt = 0;
  int  m_sc = 0, m_fc = 0;

  // Decide what the pipeline should do this cycle from the current inputs,
  // push the expectation, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    bit dw, lu, fl_ev, stalled;
    int nmode;
    dw = mem_req && !dhit;
    lu = ex_dataread && ex_wsel != 0 && (ex_wsel == id_rs || ex_wsel == id_rt);
    e.h = m_halt; e.sc = m_sc; e.fc = m_fc;
    e.en = 5'b00000; e.fl = 2'b00; e.st = FULL; fl_ev = 0; nmode = m_mode;
    if (RST) begin
      nmode = 0;
    end else if (m_mode == 0) begin
      if (dw)               begin e.en = 5'b00000; e.fl = 2'b00; e.st = FULL; end
      else if (ex_halt)     begin e.en = 5'b01111; e.fl = 2'b11; e.st = IFID; end
      else if (ex_br_taken) begin e.en = 5'b11111; e.fl = 2'b11; e.st = NO; fl_ev = 1; end
      else if (!ihit)       begin e.en = 5'b01111; e.fl = 2'b10; e.st = IFID; end
      else if (lu)          begin e.en = 5'b00111; e.fl = 2'b01; e.st = IFID; end
      else if (id_jump)     begin e.en = 5'b11111; e.fl = 2'b10; e.st = NO; fl_ev = 1; end
      else                  begin e.en = 5'b11111; e.fl = 2'b00; e.st = NO; end
      if (wb_halt) nmode = 2; else if (ex_halt && !dw) nmode = 1;
    end else if (m_mode == 1) begin
      e.en = dw ? 5'b01100 : 5'b01111; e.fl = 2'b11; e.st = dw ? FULL : IFID;
      if (wb_halt) nmode = 2;
    end
    q.push_back(e);
    stalled = !RST && m_mode != 2 && e.st != NO;
    if (RST) begin
      m_sc = 0; m_fc = 0; m_halt = 0;
    end else begin
      if (stalled) m_sc = (m_sc + 1 > SAT) ? SAT : m_sc + 1;
      if (fl_ev)   m_fc = (m_fc + 1 > SAT) ? SAT : m_fc + 1;
      m_halt = (nmode == 2);
    end
    m_mode = nmode;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; mem_req = 0; id_rs = 1; id_rt = 2;
    ex_dataread = 0; ex_wsel = 0; ex_br_taken = 0; id_jump = 0;
    ex_halt = 0; wb_halt = 0;
  endtask

  // One cycle: inputs are applied just after the rising edge.
  task automatic cyc();
    step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(int n);
    idle(); RST = 1;
    repeat (n) cyc();
    RST = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), int'(e.en));
      chk("flushes", int'({ifid_flush, idex_flush}), int'(e.fl));
      chk("stall", int'(stall), int'(e.st));
      chk("halt", int'(halt), int'(e.h));
      chk("stall_cycles", int'(stall_cycles), e.sc);
      chk("flush_count", int'(flush_count), e.fc);
    end
  end

  initial begin
    idle(); RST = 1;
    @(posedge CLK); #1;
    do_reset(2);
    // Clean run
    repeat (10) cyc();
    // Load-use on rt, then same with r0 destination
    ex_dataread = 1; ex_wsel = 5; id_rt = 5; cyc();
    ex_wsel = 0; id_rt = 0; cyc();
    idle(); cyc();
    // Dmem wait masks a taken branch, which then flushes once data arrives
    mem_req = 1; dhit = 0; ex_br_taken = 1; repeat (3) cyc();
    dhit = 1; cyc();
    idle(); cyc();
    // Taken branch beats an imem miss
    ex_br_taken = 1; ihit = 0; cyc();
    idle(); cyc();
    // Jump, then halt drain
    id_jump = 1; cyc(); idle();
    ex_halt = 1; cyc(); ex_halt = 0;
    cyc();
    wb_halt = 1; cyc(); wb_halt = 0;
    repeat (20) cyc();
    do_reset(1);
    cyc();
    // Direct halt from run
    wb_halt = 1; cyc(); idle(); repeat (3) cyc();
    // Reset mid-drain and mid-dmem-wait
    do_reset(1);
    ex_halt = 1; cyc(); idle(); mem_req = 1; dhit = 0; cyc();
    RST = 1; cyc(); idle(); repeat (2) cyc();
    mem_req = 1; dhit = 0; repeat (2) cyc(); RST = 1; cyc(); idle(); cyc();
    // Saturate stall_cycles with 20 imem-wait cycles
    ihit = 0; repeat (20) cyc(); idle(); repeat (2) cyc();
    // Saturate flush_count
    id_jump = 1; repeat (20) cyc(); idle(); cyc();
    // Randomized traffic with occasional resets
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      RST         = ($urandom_range(0, 99) == 0);
      ihit        = ($urandom_range(0, 4) != 0);
      dhit        = ($urandom_range(0, 3) != 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_wsel     = 5'($urandom_range(0, 3));
      ex_dataread = ($urandom_range(0, 2) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      id_jump     = ($urandom_range(0, 7) == 0);
      ex_halt     = ($urandom_range(0, 49) == 0);
      wb_halt     = ($urandom_range(0, 59) == 0);
      cyc();
    end
    idle();
    repeat (3) @(posedge CLK);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
